// File: rtl/time_mode_pkg.sv
// Shared types and constants for the pong time-mode front end.
// Contents:
//   state_e   - controller state encoding (SET=0, RUN=1, DONE=2; 3 is unused)
//   BTN_*     - bit positions of the three buttons in the btn bus
//   TIME_W    - width of the countdown limit
package time_mode_pkg;

  localparam int unsigned TIME_W = 8;

  localparam int unsigned BTN_UP    = 0;
  localparam int unsigned BTN_DOWN  = 1;
  localparam int unsigned BTN_START = 2;

  typedef enum logic [1:0] {
    ST_SET  = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Single push-button conditioner: 2-FF synchronizer, counter-based debounce and
// a registered rising-edge pulse.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-high reset
//   raw    in   asynchronous button input
//   level  out  debounced button level
//   press  out  one-cycle pulse on the rising edge of level
// Raw edge to press pulse is 2 + DEB_CYCLES + 1 cycles.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             level_prev_q;
  logic             press_q;

  // Count consecutive cycles of disagreement; the DEB_CYCLES-th one flips the level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= raw;
      sync2_q      <= sync1_q;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/time_setter.sv
// Time-mode front end: debounces up/down/start buttons, lets the player choose
// the countdown limit in SET, and drives the countdown reload/run controls.
// Ports:
//   clk          in   system clock
//   reset        in   synchronous active-high reset
//   btn[2:0]     in   raw buttons: [0]=up, [1]=down, [2]=start/stop
//   time_up      in   countdown reached zero
//   max_time     out  countdown limit
//   timer_reset  out  hold the countdown reloaded at max_time
//   running      out  countdown active
//   state_o      out  current state (SET=0, RUN=1, DONE=2)
// Build option: define TIME_SETTER_AUTO_REPEAT_EN to auto-repeat a held up/down
// in SET (first repeat REPEAT_DELAY cycles after the press, then every REPEAT_RATE).
module time_setter
  import time_mode_pkg::*;
#(
  parameter int unsigned DEB_CYCLES   = 1_000_000,
  parameter int unsigned T_MIN        = 5,
  parameter int unsigned T_MAX        = 99,
  parameter int unsigned T_STEP       = 5,
  parameter int unsigned T_DEFAULT    = 20,
  parameter int unsigned REPEAT_DELAY = 50_000_000,
  parameter int unsigned REPEAT_RATE  = 10_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        btn,
  input  logic              time_up,
  output logic [TIME_W-1:0] max_time,
  output logic              timer_reset,
  output logic              running,
  output logic [1:0]        state_o
);

  if (T_MAX > 255 || T_MIN > T_MAX || T_DEFAULT < T_MIN || T_DEFAULT > T_MAX) begin : gen_t_err
    $error("time_setter: T_MIN <= T_DEFAULT <= T_MAX <= 255 violated");
  end
  if (REPEAT_DELAY == 0 || REPEAT_RATE == 0) begin : gen_rep_err
    $error("time_setter: REPEAT_DELAY and REPEAT_RATE must be non-zero");
  end

  logic [2:0] level, press;

  for (genvar i = 0; i < 3; i++) begin : gen_deb
    btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .raw  (btn[i]),
      .level(level[i]),
      .press(press[i])
    );
  end

  state_e            state_q, state_d;
  logic [TIME_W-1:0] max_time_q, max_time_d;
  logic              timer_reset_q, timer_reset_d;
  logic              running_q, running_d;

  logic rep_fire;
  logic unused_level;

`ifdef TIME_SETTER_AUTO_REPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RepW   = $clog2(RepMax + 1);

  logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
  logic            rep_first_q, rep_first_d;
  logic            rep_held;

  assign unused_level = level[BTN_START];
  assign rep_held     = (level[BTN_UP] ^ level[BTN_DOWN]) && (state_q == ST_SET);

  // rep_cnt counts cycles since the press (or last repeat); the first period is longer.
  always_comb begin
    rep_fire    = 1'b0;
    rep_cnt_d   = rep_cnt_q + 1'b1;
    rep_first_d = rep_first_q;
    if (!rep_held) begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b1;
    end else if (press[BTN_UP] || press[BTN_DOWN]) begin
      rep_cnt_d   = RepW'(1);
      rep_first_d = 1'b1;
    end else if (rep_cnt_q == (rep_first_q ? RepW'(REPEAT_DELAY) : RepW'(REPEAT_RATE))) begin
      rep_fire    = 1'b1;
      rep_cnt_d   = RepW'(1);
      rep_first_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end
`else
  assign rep_fire     = 1'b0;
  assign unused_level = ^level;
`endif

  logic              inc, dec;
  logic [8:0]        up_sum;
  logic signed [8:0] dn_diff;
  logic [TIME_W-1:0] up_val, dn_val;

  assign inc = (press[BTN_UP] & ~press[BTN_DOWN]) | (rep_fire & level[BTN_UP]);
  assign dec = (press[BTN_DOWN] & ~press[BTN_UP]) | (rep_fire & level[BTN_DOWN]);

  // Sum stays unsigned (can reach 510); the difference needs a sign to catch underflow.
  assign up_sum  = {1'b0, max_time_q} + 9'(T_STEP);
  assign dn_diff = $signed({1'b0, max_time_q}) - $signed(9'(T_STEP));
  assign up_val  = (up_sum > 9'(T_MAX)) ? TIME_W'(T_MAX) : up_sum[TIME_W-1:0];
  assign dn_val  = (dn_diff < $signed(9'(T_MIN))) ? TIME_W'(T_MIN) : dn_diff[TIME_W-1:0];

  always_comb begin
    state_d       = state_q;
    max_time_d    = max_time_q;
    timer_reset_d = 1'b1;
    running_d     = 1'b0;
    case (state_q)
      ST_SET: begin
        // Start takes priority; a coincident step is dropped.
        if (press[BTN_START]) begin
          state_d = ST_RUN;
        end else if (inc && !dec) begin
          max_time_d = up_val;
        end else if (dec && !inc) begin
          max_time_d = dn_val;
        end
      end
      ST_RUN: begin
        if (time_up) begin
          state_d = ST_DONE;
        end else if (press[BTN_START]) begin
          state_d = ST_SET;
        end
      end
      ST_DONE: begin
        if (press[BTN_START]) begin
          state_d = ST_SET;
        end
      end
      default: begin
        state_d    = ST_SET;
        max_time_d = TIME_W'(T_DEFAULT);
      end
    endcase

    case (state_d)
      ST_RUN: begin
        timer_reset_d = 1'b0;
        running_d     = 1'b1;
      end
      ST_DONE: begin
        timer_reset_d = 1'b0;
        running_d     = 1'b0;
      end
      default: begin
        timer_reset_d = 1'b1;
        running_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_SET;
      max_time_q    <= TIME_W'(T_DEFAULT);
      timer_reset_q <= 1'b1;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      max_time_q    <= max_time_d;
      timer_reset_q <= timer_reset_d;
      running_q     <= running_d;
    end
  end

  assign max_time    = max_time_q;
  assign timer_reset = timer_reset_q;
  assign running     = running_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_time_setter.sv
// Bench for time_setter with short debounce/repeat constants.
module tb_time_setter;

  localparam int DEB   = 4;
  localparam int RDLY  = 20;
  localparam int RRATE = 8;

  localparam int OP_UP       = 0;
  localparam int OP_DOWN     = 1;
  localparam int OP_START    = 2;
  localparam int OP_TIMEUP   = 3;
  localparam int OP_BOTH     = 4;
  localparam int OP_START_UP = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] btn = 3'b000;
  logic       time_up = 1'b0;
  logic [7:0] max_time;
  logic       timer_reset;
  logic       running;
  logic [1:0] state_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: state 0=SET 1=RUN 2=DONE and the selected limit.
  int m_state = 0;
  int m_max   = 20;

  typedef struct {
    int op;
    int hold;
    int count;
    int exp_max;
    int exp_state;
  } vec_t;

  vec_t vecs[19];

  time_setter #(
    .DEB_CYCLES  (DEB),
    .T_MIN       (5),
    .T_MAX       (99),
    .T_STEP      (5),
    .T_DEFAULT   (20),
    .REPEAT_DELAY(RDLY),
    .REPEAT_RATE (RRATE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn        (btn),
    .time_up    (time_up),
    .max_time   (max_time),
    .timer_reset(timer_reset),
    .running    (running),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, required finish before timeout");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic check_vals(input string tag, input int e_max, input int e_state);
    check({tag, ".max_time"}, int'(max_time), e_max);
    check({tag, ".state_o"}, int'(state_o), e_state);
    check({tag, ".timer_reset"}, int'(timer_reset), (e_state == 0) ? 1 : 0);
    check({tag, ".running"}, int'(running), (e_state == 1) ? 1 : 0);
  endtask

  function automatic int sat_up(input int m);
    return (m + 5 > 99) ? 99 : m + 5;
  endfunction

  function automatic int sat_dn(input int m);
    return (m - 5 < 5) ? 5 : m - 5;
  endfunction

  // A press registers only if the raw level survives DEB consecutive samples.
  task automatic model_op(input int op, input int hold);
    bit fires;
    bit has_start;
    fires     = (op == OP_TIMEUP) || (hold >= DEB);
    has_start = fires && (op == OP_START || op == OP_START_UP);
    if (!fires) return;
    case (m_state)
      0: begin
        if (has_start) m_state = 1;
        else if (op == OP_UP) m_max = sat_up(m_max);
        else if (op == OP_DOWN) m_max = sat_dn(m_max);
      end
      1: begin
        if (op == OP_TIMEUP) m_state = 2;
        else if (has_start) m_state = 0;
      end
      default: begin
        if (has_start) m_state = 0;
      end
    endcase
  endtask

  task automatic drive_op(input int op, input int hold);
    if (op == OP_TIMEUP) begin
      time_up = 1'b1;
      tick(1);
      time_up = 1'b0;
      tick(2);
    end else begin
      case (op)
        OP_UP:    btn = 3'b001;
        OP_DOWN:  btn = 3'b010;
        OP_START: btn = 3'b100;
        OP_BOTH:  btn = 3'b011;
        default:  btn = 3'b101;
      endcase
      tick(hold);
      btn = 3'b000;
      tick(12);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    m_state = 0;
    m_max   = 20;
  endtask

  initial begin
    int exp_rep;
    int steps;

    vecs[0]  = '{OP_UP,       10, 1,  30, 0};
    vecs[1]  = '{OP_UP,       10, 1,  35, 0};
    vecs[2]  = '{OP_UP,        3, 1,  35, 0};
    vecs[3]  = '{OP_DOWN,     10, 5,  10, 0};
    vecs[4]  = '{OP_DOWN,     10, 1,   5, 0};
    vecs[5]  = '{OP_DOWN,     10, 1,   5, 0};
    vecs[6]  = '{OP_UP,       10, 18, 95, 0};
    vecs[7]  = '{OP_UP,       10, 1,  99, 0};
    vecs[8]  = '{OP_UP,       10, 1,  99, 0};
    vecs[9]  = '{OP_BOTH,     10, 1,  99, 0};
    vecs[10] = '{OP_START,    10, 1,  99, 1};
    vecs[11] = '{OP_UP,       10, 1,  99, 1};
    vecs[12] = '{OP_TIMEUP,    1, 1,  99, 2};
    vecs[13] = '{OP_DOWN,     10, 1,  99, 2};
    vecs[14] = '{OP_START,    10, 1,  99, 0};
    vecs[15] = '{OP_DOWN,     10, 1,  94, 0};
    vecs[16] = '{OP_START_UP, 10, 1,  94, 1};
    vecs[17] = '{OP_START,    10, 1,  94, 0};
    vecs[18] = '{OP_START,    10, 1,  94, 1};

    // Reset, then idle: a button held through reset must not act early.
    btn = 3'b001;
    do_reset();
    btn = 3'b000;
    tick(12);
    check_vals("reset", 20, 0);

    // Step lands exactly 8 cycles after the raw edge.
    btn = 3'b001;
    tick(7);
    check("latency.before", int'(max_time), 20);
    tick(1);
    check("latency.at", int'(max_time), 25);
    tick(2);
    btn = 3'b000;
    tick(12);
    model_op(OP_UP, 10);

    for (int i = 0; i < 19; i++) begin
      for (int k = 0; k < vecs[i].count; k++) begin
        drive_op(vecs[i].op, vecs[i].hold);
        model_op(vecs[i].op, vecs[i].hold);
      end
      check_vals($sformatf("vec%0d", i), vecs[i].exp_max, vecs[i].exp_state);
    end

    // RUN: time_up and a start press on the same edge -> DONE.
    btn = 3'b100;
    tick(7);
    check("tu_start.pre_state", int'(state_o), 1);
    time_up = 1'b1;
    tick(1);
    time_up = 1'b0;
    check_vals("tu_start", 94, 2);
    btn = 3'b000;
    tick(12);
    check_vals("tu_start.after", 94, 2);
    m_state = 2;

    // Held up for 60 cycles from the default value.
    do_reset();
    btn = 3'b001;
    tick(60);
    btn = 3'b000;
    tick(20);
`ifdef TIME_SETTER_AUTO_REPEAT_EN
    // Level is high through edge 66; press acts at edge 8, repeats every RATE after DELAY.
    steps = 1;
    for (int e = 8 + RDLY; e <= 60 + 6; e += RRATE) steps++;
    exp_rep = 20 + 5 * steps;
`else
    steps   = 1;
    exp_rep = 20 + 5 * steps;
`endif
    check_vals("hold60", exp_rep, 0);
    m_max = exp_rep;

    // Reset mid-RUN loses the selected value.
    drive_op(OP_START, 10);
    model_op(OP_START, 10);
    check_vals("prerst_run", m_max, 1);
    reset = 1'b1;
    tick(1);
    check_vals("rst_midrun", 20, 0);
    reset = 1'b0;
    tick(1);
    m_state = 0;
    m_max   = 20;

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      int op;
      int hold;
      op   = int'($urandom_range(0, 5));
      hold = int'($urandom_range(1, 14));
      drive_op(op, hold);
      model_op(op, hold);
      check_vals($sformatf("rnd%0d(op%0d,h%0d)", i, op, hold), m_max, m_state);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
